// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: runtime-configurable oversampling UART receiver.
// Frame format: start, SIZE_DATA data bits LSB first, optional even/odd parity,
// one or two stop bits. Each bit is resolved by a 2-of-3 vote around mid-bit.
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_stick                 oversample tick, OVER_SAMPLE ticks per bit
//   i_rx_en                 gates detection of new start bits only
//   i_parity_en/odd, i_stop2  frame format, latched when a frame starts
//   i_fifo_full             a finished frame is dropped (o_overrun) when high
//   i_rx_serial             asynchronous serial line, idle high
//   o_rx_data, o_rx_valid   received word and its one-cycle valid pulse
//   o_parity_err, o_frame_err, o_break  flags qualified by o_rx_valid
//   o_overrun               one-cycle pulse for a dropped frame
//   o_busy                  receiver is inside a frame
module uart_rx_cfg #(
    parameter int SIZE_DATA   = 8,
    parameter int OVER_SAMPLE = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_stick,
    input  logic                 i_rx_en,
    input  logic                 i_parity_en,
    input  logic                 i_parity_odd,
    input  logic                 i_stop2,
    input  logic                 i_fifo_full,
    input  logic                 i_rx_serial,
    output logic [SIZE_DATA-1:0] o_rx_data,
    output logic                 o_rx_valid,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_break,
    output logic                 o_overrun,
    output logic                 o_busy
);
    localparam int CW  = $clog2(OVER_SAMPLE);
    localparam int IW  = $clog2(SIZE_DATA);
    localparam int MID = OVER_SAMPLE / 2;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

    state_t               state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                 rx_prev_q, rx_prev_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [1:0]           smp_q, smp_d;
    logic [SIZE_DATA-1:0] shift_q, shift_d;
    logic                 par_en_q, par_en_d;
    logic                 par_odd_q, par_odd_d;
    logic                 stop2_q, stop2_d;
    logic                 par_bit_q, par_bit_d;
    logic                 ferr_q, ferr_d;
    logic [SIZE_DATA-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 break_q, break_d;
    logic                 overrun_q, overrun_d;
    logic                 rx_s, fall, at_mid, at_end, vote, ferr_fin, finish;

    assign rx_s     = sync_q[SYNC_STAGES-1];
    assign fall     = rx_prev_q & ~rx_s;
    assign at_mid   = i_stick && (cnt_q == CW'(MID));
    assign at_end   = i_stick && (cnt_q == CW'(OVER_SAMPLE - 1));
    // two earlier samples plus the live sample on the MID tick
    assign vote     = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);
    // includes the stop bit being resolved on this very tick
    assign ferr_fin = ferr_q | ~vote;

    always_comb begin
        sync_d       = {sync_q[SYNC_STAGES-2:0], i_rx_serial};
        rx_prev_d    = rx_s;
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        smp_d        = smp_q;
        shift_d      = shift_q;
        par_en_d     = par_en_q;
        par_odd_d    = par_odd_q;
        stop2_d      = stop2_q;
        par_bit_d    = par_bit_q;
        ferr_d       = ferr_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;
        break_d      = 1'b0;
        overrun_d    = 1'b0;
        finish       = 1'b0;
        if (state_q != IDLE && i_stick) begin
            cnt_d = at_end ? '0 : cnt_q + CW'(1);
            if (cnt_q == CW'(MID - 2)) smp_d[0] = rx_s;
            if (cnt_q == CW'(MID - 1)) smp_d[1] = rx_s;
        end
        case (state_q)
            START: begin
                if (at_mid && vote) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (at_end) begin
                    state_d = DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (at_mid) shift_d = {vote, shift_q[SIZE_DATA-1:1]};
                if (at_end) begin
                    idx_d = idx_q + IW'(1);
                    if (idx_q == IW'(SIZE_DATA - 1)) state_d = par_en_q ? PARITY : STOP1;
                end
            end
            PARITY: begin
                if (at_mid) par_bit_d = vote;
                if (at_end) state_d = STOP1;
            end
            STOP1: begin
                if (at_mid) begin
                    ferr_d = ferr_fin;
                    finish = !stop2_q;
                end
                if (at_end) state_d = STOP2;
            end
            STOP2: finish = at_mid;
            default: ;
        endcase
        // finishing at mid stop bit leaves half a bit to catch the next start edge
        if (finish) begin
            state_d = IDLE;
            cnt_d   = '0;
            if (i_fifo_full) begin
                overrun_d = 1'b1;
            end else begin
                rx_valid_d   = 1'b1;
                rx_data_d    = shift_q;
                parity_err_d = par_en_q & (par_bit_q ^ (^shift_q) ^ par_odd_q);
                frame_err_d  = ferr_fin;
                break_d      = ferr_fin & ~(|shift_q) & ~(par_en_q & par_bit_q);
            end
        end
        if ((state_q == IDLE || finish) && fall && i_rx_en) begin
            state_d   = START;
            cnt_d     = '0;
            ferr_d    = 1'b0;
            par_en_d  = i_parity_en;
            par_odd_d = i_parity_odd;
            stop2_d   = i_stop2;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= IDLE;
            sync_q       <= '1;
            rx_prev_q    <= 1'b1;
            cnt_q        <= '0;
            idx_q        <= '0;
            smp_q        <= '0;
            shift_q      <= '0;
            par_en_q     <= 1'b0;
            par_odd_q    <= 1'b0;
            stop2_q      <= 1'b0;
            par_bit_q    <= 1'b0;
            ferr_q       <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            break_q      <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            rx_prev_q    <= rx_prev_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            smp_q        <= smp_d;
            shift_q      <= shift_d;
            par_en_q     <= par_en_d;
            par_odd_q    <= par_odd_d;
            stop2_q      <= stop2_d;
            par_bit_q    <= par_bit_d;
            ferr_q       <= ferr_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            break_q      <= break_d;
            overrun_q    <= overrun_d;
        end
    end

    assign o_rx_data    = rx_data_q;
    assign o_rx_valid   = rx_valid_q;
    assign o_parity_err = parity_err_q;
    assign o_frame_err  = frame_err_q;
    assign o_break      = break_q;
    assign o_overrun    = overrun_q;
    assign o_busy       = (state_q != IDLE);
endmodule
